// File: rtl/decode_stage.sv
// RV32I decode stage: splits the fetched instruction into register indices, immediate and
// control signals, registers them at the ID/EX boundary, and requests a stall on load-use.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  input  logic            stall_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instruction_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic [31:0]     imm_out,
  output logic [2:0]      funct3_out,
  output logic [3:0]      alu_op_out,
  output logic            alu_src_imm_out,
  output logic            alu_src_pc_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            branch_out,
  output logic            jump_out,
  output logic            illegal_out
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcBr    = 7'b1100011;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSll   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluSlt   = 4'd8;
  localparam logic [3:0] AluSltu  = 4'd9;
  localparam logic [3:0] AluPassb = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ex_t;

  // alt selects SUB/SRA in the funct3 slots that share an encoding
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instruction_in[6:0];
  assign rd     = instruction_in[11:7];
  assign funct3 = instruction_in[14:12];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];
  assign funct7 = instruction_in[31:25];
  assign imm_i  = {{20{instruction_in[31]}}, instruction_in[31:20]};
  assign imm_s  = {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
  assign imm_b  = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                   instruction_in[30:25], instruction_in[11:8], 1'b0};
  assign imm_u  = {instruction_in[31:12], 12'b0};
  assign imm_j  = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                   instruction_in[20], instruction_in[30:21], 1'b0};

  id_ex_t          bubble;
  id_ex_t          fields;
  id_ex_t          dec;
  id_ex_t          id_ex_q;
  logic [XLEN-1:0] pc_q;
  logic            legal;
  logic            writes;
  logic            uses_rs1;
  logic            uses_rs2;

  always_comb begin
    bubble       = '0;
    bubble.instr = NOP_INSTR;
  end

  always_comb begin
    fields   = bubble;
    legal    = 1'b0;
    writes   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpcOp: begin
        legal    = (funct7 == 7'h00) ||
                   (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        writes   = 1'b1;
        fields.alu_op = alu_from_funct3(funct3, funct7[5]);
      end
      OpcOpImm: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
        uses_rs1 = 1'b1;
        writes   = 1'b1;
        fields.imm         = imm_i;
        fields.alu_src_imm = 1'b1;
        fields.alu_op      = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
      end
      OpcLoad: begin
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        uses_rs1 = 1'b1;
        writes   = 1'b1;
        fields.imm         = imm_i;
        fields.alu_src_imm = 1'b1;
        fields.mem_read    = 1'b1;
      end
      OpcStore: begin
        legal    = (funct3[2] == 1'b0) && (funct3 != 3'b011);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        fields.imm         = imm_s;
        fields.alu_src_imm = 1'b1;
        fields.mem_write   = 1'b1;
      end
      OpcBr: begin
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        fields.imm    = imm_b;
        fields.alu_op = AluSub;
        fields.branch = 1'b1;
      end
      OpcJal: begin
        legal  = 1'b1;
        writes = 1'b1;
        fields.imm         = imm_j;
        fields.alu_src_imm = 1'b1;
        fields.alu_src_pc  = 1'b1;
        fields.jump        = 1'b1;
      end
      OpcJalr: begin
        legal    = (funct3 == 3'b000);
        uses_rs1 = 1'b1;
        writes   = 1'b1;
        fields.imm         = imm_i;
        fields.alu_src_imm = 1'b1;
        fields.jump        = 1'b1;
      end
      OpcLui: begin
        legal  = 1'b1;
        writes = 1'b1;
        fields.imm         = imm_u;
        fields.alu_src_imm = 1'b1;
        fields.alu_op      = AluPassb;
      end
      OpcAuipc: begin
        legal  = 1'b1;
        writes = 1'b1;
        fields.imm         = imm_u;
        fields.alu_src_imm = 1'b1;
        fields.alu_src_pc  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    fields.rs1       = uses_rs1 ? rs1 : 5'd0;
    fields.rs2       = uses_rs2 ? rs2 : 5'd0;
    fields.reg_write = writes && (rd != 5'd0);
    fields.rd        = fields.reg_write ? rd : 5'd0;
  end

  // Illegal encodings stay live but carry no register, immediate or side-effect fields
  always_comb begin
    dec = bubble;
    if (valid_in) begin
      if (legal) dec = fields;
      else       dec.illegal = 1'b1;
      dec.valid  = 1'b1;
      dec.instr  = instruction_in;
      dec.funct3 = funct3;
    end
  end

  logic hazard_rs1;
  logic hazard_rs2;

  assign hazard_rs1 = legal && uses_rs1 && (rs1 == id_ex_q.rd);
  assign hazard_rs2 = legal && uses_rs2 && (rs2 == id_ex_q.rd);
  assign stall_out  = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                      valid_in && !flush_in && (hazard_rs1 || hazard_rs2);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q <= bubble;
      pc_q    <= '0;
    end else if (flush_in) begin
      id_ex_q <= bubble;
      pc_q    <= pc_in;
    end else if (!stall_in) begin
      id_ex_q <= stall_out ? bubble : dec;
      pc_q    <= pc_in;
    end
  end

  assign valid_out       = id_ex_q.valid;
  assign pc_out          = pc_q;
  assign instruction_out = id_ex_q.instr;
  assign rs1_out         = id_ex_q.rs1;
  assign rs2_out         = id_ex_q.rs2;
  assign rd_out          = id_ex_q.rd;
  assign imm_out         = id_ex_q.imm;
  assign funct3_out      = id_ex_q.funct3;
  assign alu_op_out      = id_ex_q.alu_op;
  assign alu_src_imm_out = id_ex_q.alu_src_imm;
  assign alu_src_pc_out  = id_ex_q.alu_src_pc;
  assign reg_write_out   = id_ex_q.reg_write;
  assign mem_read_out    = id_ex_q.mem_read;
  assign mem_write_out   = id_ex_q.mem_write;
  assign branch_out      = id_ex_q.branch;
  assign jump_out        = id_ex_q.jump;
  assign illegal_out     = id_ex_q.illegal;

endmodule
